// File: rtl/switch_irq_sequencer.sv
// switch_irq_sequencer
// Avalon-MM master for the 10-bit switch PIO. It programs the PIO IRQ mask,
// services the switch interrupt (read edge_capture, clear it, read levels)
// and presents one event word per serviced interrupt on a valid/ready
// stream. The PIO returns readdata one cycle after the address is driven,
// so every read is followed by a cycle in which that data is sampled.
module switch_irq_sequencer #(
   parameter int                DATA_W        = 10,
   parameter logic [DATA_W-1:0] IRQ_MASK_INIT = 10'h3FF,
   parameter int                CNT_W         = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   output logic [1:0]        avm_address,
   output logic              avm_chipselect,
   output logic              avm_write_n,
   output logic [31:0]       avm_writedata,
   input  logic [31:0]       avm_readdata,
   input  logic              irq,
   input  logic              cfg_mask_valid,
   input  logic [DATA_W-1:0] cfg_mask,
   output logic              cfg_mask_ready,
   output logic              evt_valid,
   input  logic              evt_ready,
   output logic [DATA_W-1:0] evt_edges,
   output logic [DATA_W-1:0] evt_level,
   output logic [CNT_W-1:0]  evt_count,
   output logic              busy
);

   // PIO register map
   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_MASK = 2'd2;
   localparam logic [1:0] ADDR_ECAP = 2'd3;

   typedef enum logic [2:0] {
      S_MASK = 3'd0,
      S_IDLE = 3'd1,
      S_RCAP = 3'd2,
      S_CLR  = 3'd3,
      S_RDAT = 3'd4,
      S_LAT  = 3'd5,
      S_OUT  = 3'd6
   } state_t;

   // One registered Avalon command: everything the master drives on the bus.
   typedef struct packed {
      logic        cs;
      logic        wn;
      logic [1:0]  addr;
      logic [31:0] wd;
   } bus_t;

   // Zero-extend a PIO-width value onto the 32-bit write bus.
   function automatic logic [31:0] pad_word(input logic [DATA_W-1:0] v);
      pad_word = {{(32-DATA_W){1'b0}}, v};
   endfunction

   // Bus at rest: not selected, write strobe inactive, address parked at 0.
   function automatic bus_t bus_idle();
      bus_t b;
      b.cs   = 1'b0;
      b.wn   = 1'b1;
      b.addr = 2'd0;
      b.wd   = 32'd0;
      return b;
   endfunction

   // Single-cycle write of data to a PIO register.
   function automatic bus_t bus_write(input logic [1:0] a, input logic [31:0] d);
      bus_t b;
      b.cs   = 1'b1;
      b.wn   = 1'b0;
      b.addr = a;
      b.wd   = d;
      return b;
   endfunction

   // Single-cycle read of a PIO register.
   function automatic bus_t bus_read(input logic [1:0] a);
      bus_t b;
      b.cs   = 1'b1;
      b.wn   = 1'b1;
      b.addr = a;
      b.wd   = 32'd0;
      return b;
   endfunction

   state_t              state_q;
   bus_t                bus_q;
   logic [DATA_W-1:0]   mask_q;
   logic [DATA_W-1:0]   edges_q;
   logic [DATA_W-1:0]   level_q;
   logic [CNT_W-1:0]    count_q;
   logic                evt_valid_q;
   logic                cfg_ready_q;
   logic                busy_q;
   logic [DATA_W-1:0]   rd_field_s;
   logic                unused_rd_s;

   // Only the low PIO-width bits of readdata carry information.
   assign rd_field_s  = avm_readdata[DATA_W-1:0];
   assign unused_rd_s = ^avm_readdata[31:DATA_W];

   // Sequencer FSM; every output is registered on the transition into the
   // state that owns it, so the bus shows a state's command during that state.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_MASK;
         bus_q       <= bus_idle();
         mask_q      <= IRQ_MASK_INIT;
         edges_q     <= {DATA_W{1'b0}};
         level_q     <= {DATA_W{1'b0}};
         count_q     <= {CNT_W{1'b0}};
         evt_valid_q <= 1'b0;
         cfg_ready_q <= 1'b0;
         busy_q      <= 1'b1;
      end else begin
         cfg_ready_q <= 1'b0;
         case (state_q)
            S_MASK: begin
               // Entered from S_IDLE the write is already on the bus; coming
               // out of reset the bus is still idle, so issue the write now.
               if (bus_q.cs) begin
                  state_q <= S_IDLE;
                  bus_q   <= bus_idle();
                  busy_q  <= 1'b0;
               end else begin
                  state_q <= S_MASK;
                  bus_q   <= bus_write(ADDR_MASK, pad_word(mask_q));
                  busy_q  <= 1'b1;
               end
            end
            S_IDLE: begin
               // A pending reconfiguration wins over a pending interrupt.
               if (cfg_mask_valid) begin
                  mask_q      <= cfg_mask;
                  cfg_ready_q <= 1'b1;
                  state_q     <= S_MASK;
                  bus_q       <= bus_write(ADDR_MASK, pad_word(cfg_mask));
                  busy_q      <= 1'b1;
               end else if (irq) begin
                  state_q <= S_RCAP;
                  bus_q   <= bus_read(ADDR_ECAP);
                  busy_q  <= 1'b1;
               end else begin
                  state_q <= S_IDLE;
                  bus_q   <= bus_idle();
                  busy_q  <= 1'b0;
               end
            end
            S_RCAP: begin
               // Clearing with all ones also erases any capture bit that set
               // after the read was issued; that narrow window is accepted.
               state_q <= S_CLR;
               bus_q   <= bus_write(ADDR_ECAP, pad_word({DATA_W{1'b1}}));
               busy_q  <= 1'b1;
            end
            S_CLR: begin
               edges_q <= rd_field_s & mask_q;
               state_q <= S_RDAT;
               bus_q   <= bus_read(ADDR_DATA);
               busy_q  <= 1'b1;
            end
            S_RDAT: begin
               state_q <= S_LAT;
               bus_q   <= bus_idle();
               busy_q  <= 1'b1;
            end
            S_LAT: begin
               level_q <= rd_field_s;
               bus_q   <= bus_idle();
               // No enabled edge captured: the interrupt was spurious.
               if (edges_q == {DATA_W{1'b0}}) begin
                  state_q     <= S_IDLE;
                  evt_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
               end else begin
                  state_q     <= S_OUT;
                  evt_valid_q <= 1'b1;
                  busy_q      <= 1'b1;
               end
            end
            S_OUT: begin
               bus_q <= bus_idle();
               if (evt_valid_q && evt_ready) begin
                  count_q     <= count_q + CNT_W'(1);
                  evt_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
                  busy_q      <= 1'b0;
               end else begin
                  evt_valid_q <= 1'b1;
                  state_q     <= S_OUT;
                  busy_q      <= 1'b1;
               end
            end
            default: begin
               state_q     <= S_MASK;
               bus_q       <= bus_idle();
               evt_valid_q <= 1'b0;
               busy_q      <= 1'b1;
            end
         endcase
      end
   end

   assign avm_chipselect = bus_q.cs;
   assign avm_write_n    = bus_q.wn;
   assign avm_address    = bus_q.addr;
   assign avm_writedata  = bus_q.wd;
   assign cfg_mask_ready = cfg_ready_q;
   assign evt_valid      = evt_valid_q;
   assign evt_edges      = edges_q;
   assign evt_level      = level_q;
   assign evt_count      = count_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_switch_irq_sequencer.sv
// Bench for switch_irq_sequencer: a behavioural switch PIO (any-edge capture,
// registered readdata) plus table-driven toggle vectors and hand sequences.
`timescale 1ns/1ps
module tb_switch_irq_sequencer;
   localparam int DW = 10;
   localparam int CW = 16;

   logic          clk = 1'b0;
   logic          reset_n;
   logic [1:0]    avm_address;
   logic          avm_chipselect;
   logic          avm_write_n;
   logic [31:0]   avm_writedata;
   logic [31:0]   avm_readdata;
   logic          irq;
   logic          cfg_mask_valid;
   logic [DW-1:0] cfg_mask;
   logic          cfg_mask_ready;
   logic          evt_valid;
   logic          evt_ready;
   logic [DW-1:0] evt_edges;
   logic [DW-1:0] evt_level;
   logic [CW-1:0] evt_count;
   logic          busy;

   // PIO model state
   logic [DW-1:0] sw, sw_prev, pio_mask, pio_ec;
   logic [31:0]   pio_rd;
   logic          spur;

   int n_cmp = 0;
   int n_bad = 0;
   int exp_cnt = 0;
   int lat;

   typedef struct {
      logic [DW-1:0] sw;
      logic [DW-1:0] edges;
      logic [DW-1:0] level;
   } vec_t;
   vec_t tbl[4];

   always #5 clk = ~clk;

   switch_irq_sequencer dut (
      .clk(clk), .reset_n(reset_n),
      .avm_address(avm_address), .avm_chipselect(avm_chipselect),
      .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
      .avm_readdata(avm_readdata), .irq(irq),
      .cfg_mask_valid(cfg_mask_valid), .cfg_mask(cfg_mask),
      .cfg_mask_ready(cfg_mask_ready),
      .evt_valid(evt_valid), .evt_ready(evt_ready),
      .evt_edges(evt_edges), .evt_level(evt_level),
      .evt_count(evt_count), .busy(busy)
   );

   assign avm_readdata = pio_rd;
   assign irq = (|(pio_ec & pio_mask)) | spur;

   // Switch PIO: any-edge capture, write-1-to-clear, registered readdata.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sw_prev  <= sw;
         pio_mask <= '0;
         pio_ec   <= '0;
         pio_rd   <= '0;
      end else begin
         sw_prev <= sw;
         if (avm_chipselect && !avm_write_n && avm_address == 2'd2)
            pio_mask <= avm_writedata[DW-1:0];
         if (avm_chipselect && !avm_write_n && avm_address == 2'd3)
            pio_ec <= (pio_ec & ~avm_writedata[DW-1:0]) | (sw ^ sw_prev);
         else
            pio_ec <= pio_ec | (sw ^ sw_prev);
         if (avm_chipselect && avm_write_n) begin
            case (avm_address)
               2'd0:    pio_rd <= {22'd0, sw};
               2'd2:    pio_rd <= {22'd0, pio_mask};
               2'd3:    pio_rd <= {22'd0, pio_ec};
               default: pio_rd <= 32'd0;
            endcase
         end else begin
            pio_rd <= 32'd0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Count cycles until evt_valid, bounded.
   task automatic wait_evt(output int n);
      n = 0;
      while (!evt_valid && n < 40) begin
         tick();
         n++;
      end
   endtask

   initial begin
      tbl[0] = '{sw: 10'h008, edges: 10'h008, level: 10'h008};
      tbl[1] = '{sw: 10'h00C, edges: 10'h004, level: 10'h00C};
      tbl[2] = '{sw: 10'h3F3, edges: 10'h3FF, level: 10'h3F3};
      tbl[3] = '{sw: 10'h000, edges: 10'h3F3, level: 10'h000};

      sw = '0; spur = 1'b0; cfg_mask_valid = 1'b0; cfg_mask = '0; evt_ready = 1'b0;
      reset_n = 1'b0;
      repeat (3) tick();
      chk("rst_evt_valid", evt_valid, 0);
      chk("rst_busy", busy, 1);
      chk("rst_cs", avm_chipselect, 0);
      chk("rst_write_n", avm_write_n, 1);
      chk("rst_count", evt_count, 0);
      chk("rst_pio_mask", pio_mask, 0);

      // Reset release: mask write of 0x3FF on the first cycle.
      reset_n = 1'b1;
      tick();
      chk("init_cs", avm_chipselect, 1);
      chk("init_write_n", avm_write_n, 0);
      chk("init_addr", avm_address, 2);
      chk("init_wdata", avm_writedata, 32'h3FF);
      tick();
      chk("init_pio_mask", pio_mask, 10'h3FF);
      chk("init_busy", busy, 0);
      chk("init_cs_off", avm_chipselect, 0);

      // Table of switch toggles, ready always high.
      evt_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         sw = tbl[i].sw;
         tick();
         chk($sformatf("v%0d_irq", i), irq, 1);
         wait_evt(lat);
         chk($sformatf("v%0d_latency", i), lat, 5);
         chk($sformatf("v%0d_edges", i), evt_edges, tbl[i].edges);
         chk($sformatf("v%0d_level", i), evt_level, tbl[i].level);
         tick();
         exp_cnt++;
         chk($sformatf("v%0d_valid_drop", i), evt_valid, 0);
         chk($sformatf("v%0d_count", i), evt_count, exp_cnt);
         chk($sformatf("v%0d_ecap_clear", i), pio_ec, 0);
         chk($sformatf("v%0d_irq_low", i), irq, 0);
      end

      // Backpressure: event held while switches 0 and 9 toggle.
      evt_ready = 1'b0;
      sw = 10'h008;
      tick();
      wait_evt(lat);
      chk("hold_first_edges", evt_edges, 10'h008);
      for (int k = 0; k < 20; k++) begin
         if (k == 3) sw = 10'h209;
         tick();
         chk($sformatf("hold_valid_%0d", k), evt_valid, 1);
         chk($sformatf("hold_edges_%0d", k), evt_edges, 10'h008);
         chk($sformatf("hold_level_%0d", k), evt_level, 10'h008);
      end
      evt_ready = 1'b1;
      tick();
      exp_cnt++;
      chk("hold_count1", evt_count, exp_cnt);
      wait_evt(lat);
      chk("hold_second_latency", lat, 5);
      chk("hold_second_edges", evt_edges, 10'h201);
      chk("hold_second_level", evt_level, 10'h209);
      tick();
      exp_cnt++;
      chk("hold_count2", evt_count, exp_cnt);

      // cfg and irq in the same idle cycle: cfg wins.
      sw = 10'h229;
      tick();
      cfg_mask_valid = 1'b1;
      cfg_mask = 10'h00F;
      chk("cfg_irq_pending", irq, 1);
      tick();
      chk("cfg_ready_pulse", cfg_mask_ready, 1);
      chk("cfg_write_n", avm_write_n, 0);
      chk("cfg_addr", avm_address, 2);
      chk("cfg_wdata", avm_writedata, 32'h00F);
      cfg_mask_valid = 1'b0;
      tick();
      chk("cfg_ready_low", cfg_mask_ready, 0);
      chk("cfg_pio_mask", pio_mask, 10'h00F);
      chk("cfg_irq_masked", irq, 0);
      for (int k = 0; k < 8; k++) begin
         tick();
         chk($sformatf("cfg_no_service_%0d", k), busy, 0);
      end
      sw = 10'h22D;
      tick();
      chk("cfg_sw2_irq", irq, 1);
      wait_evt(lat);
      chk("cfg_sw2_latency", lat, 5);
      chk("cfg_sw2_edges", evt_edges, 10'h004);
      chk("cfg_sw2_level", evt_level, 10'h22D);
      tick();
      exp_cnt++;
      chk("cfg_sw2_count", evt_count, exp_cnt);

      // Spurious interrupt: no capture bits, no event.
      spur = 1'b1;
      tick();
      spur = 1'b0;
      chk("spur_busy_rcap", busy, 1);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("spur_busy_%0d", k), busy, 1);
         chk($sformatf("spur_valid_%0d", k), evt_valid, 0);
      end
      tick();
      chk("spur_back_idle", busy, 0);
      chk("spur_no_valid", evt_valid, 0);
      chk("spur_count", evt_count, exp_cnt);

      // Reset during S_OUT discards the event and restarts.
      evt_ready = 1'b0;
      sw = 10'h22F;
      tick();
      wait_evt(lat);
      chk("rst_out_edges", evt_edges, 10'h002);
      chk("rst_out_valid", evt_valid, 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("rst_out_valid_drop", evt_valid, 0);
      chk("rst_out_count", evt_count, 0);
      chk("rst_out_busy", busy, 1);
      chk("rst_out_edges_clr", evt_edges, 0);
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      chk("rst_out_mask_wr", avm_write_n, 0);
      chk("rst_out_mask_addr", avm_address, 2);
      chk("rst_out_mask_data", avm_writedata, 32'h3FF);
      tick();
      chk("rst_out_idle", busy, 0);
      chk("rst_out_pio_mask", pio_mask, 10'h3FF);
      chk("rst_out_count_zero", evt_count, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/switch_irq_sequencer.md
Name: switch_irq_sequencer

Overview:
- Avalon-MM master that owns the 10-bit switch PIO slave: programs its IRQ mask, services its interrupt, and clears its edge-capture register.
- On each serviced interrupt, presents one event word (masked edges plus current switch levels) on a valid/ready stream to downstream game/display logic.
- Removes the need for Nios-side ISR code for switch handling.

Parameters:
- DATA_W, 10, PIO data width; applies to edges, levels and mask.
- IRQ_MASK_INIT, 10'h3FF, mask value written to the PIO after reset.
- CNT_W, 16, width of the accepted-event counter.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous assert, active-low
- avm_address  out  2  PIO register select (0 = data, 2 = irq_mask, 3 = edge_capture)
- avm_chipselect  out  1  PIO select
- avm_write_n  out  1  active-low write strobe
- avm_writedata  out  32  write data, {22'b0, value}
- avm_readdata  in  32  PIO readdata; registered in the PIO, so valid 1 cycle after the address is driven
- irq  in  1  PIO interrupt, combinational from (edge_capture & irq_mask)
- cfg_mask_valid  in  1  request to reprogram the IRQ mask
- cfg_mask  in  DATA_W  new mask value
- cfg_mask_ready  out  1  1-cycle pulse when the cfg request is accepted
- evt_valid  out  1  event word valid
- evt_ready  in  1  downstream accept
- evt_edges  out  DATA_W  captured edges ANDed with the mask
- evt_level  out  DATA_W  switch levels sampled after the clear
- evt_count  out  CNT_W  accepted events; wraps modulo 2^CNT_W
- busy  out  1  high in every state except S_IDLE

Behaviour:
- Reset values:
  - FSM = S_MASK; mask_reg = IRQ_MASK_INIT.
  - evt_valid, cfg_mask_ready, avm_chipselect = 0; avm_write_n = 1; avm_address = 0; avm_writedata = 0.
  - evt_edges, evt_level, evt_count = 0; busy = 1.
- Reset asserted mid-operation aborts immediately to the reset state. Any pending event is discarded. The mask is reprogrammed on the first cycle after release.
- All Avalon outputs are registered from the state. When chipselect = 0, the bus holds write_n = 1 and address = 0.
- States (one cycle each unless noted):
  - S_MASK: chipselect = 1, write_n = 0, address = 2, writedata = mask_reg. Next state is S_IDLE.
  - S_IDLE: bus idle.
    - If cfg_mask_valid: mask_reg <= cfg_mask, pulse cfg_mask_ready, go to S_MASK.
    - Else if irq: go to S_RCAP.
    - cfg has priority over irq when both are present.
  - S_RCAP: chipselect = 1, write_n = 1, address = 3. Next state is S_CLR.
  - S_CLR: edges_reg <= avm_readdata[DATA_W-1:0] & mask_reg. Drive chipselect = 1, write_n = 0, address = 3, writedata = all ones. This clears every capture bit in the PIO. Next state is S_RDAT.
  - S_RDAT: chipselect = 1, write_n = 1, address = 0. Next state is S_LAT.
  - S_LAT: level_reg <= avm_readdata[DATA_W-1:0].
    - If edges_reg == 0 (spurious irq): go to S_IDLE with no event.
    - Else: go to S_OUT.
  - S_OUT: evt_valid = 1; evt_edges and evt_level are held stable.
    - On evt_valid & evt_ready: evt_count increments and the FSM goes to S_IDLE.
    - evt_valid is held indefinitely without ready.
- Latency: irq high in S_IDLE at cycle 0 gives evt_valid = 1 at cycle 5.
- irq is low from S_RDAT onward unless a new edge arrives.
- Edges arriving while in S_OUT or S_IDLE accumulate (OR) in the PIO and are serviced on the next pass. They are not lost.
- Known loss window: an edge whose capture bit sets at the S_RCAP→S_CLR clock edge is erased by the S_CLR clear and never reported. This is accepted behaviour; the bench must not flag it.
- cfg_mask_valid outside S_IDLE is ignored until S_IDLE is reached. The requester holds it until cfg_mask_ready.
- The mask applied to evt_edges is mask_reg as it stood at S_CLR.

Test Plan:
- Reset release, PIO mask reads 0 beforehand → cycle 1 after reset is a write of 0x3FF to address 2; PIO irq_mask reads 0x3FF; FSM in S_IDLE, busy = 0.
- Toggle switch 3 (levels 0x000→0x008) with evt_ready = 1 → evt_valid 5 cycles after irq, evt_edges = 0x008, evt_level = 0x008, evt_count = 1; PIO edge_capture = 0 and irq low afterward.
- evt_ready held 0 for 20 cycles while switches 0 and 9 toggle → first event is held stable; after ready, a second event arrives with evt_edges = 0x201 and evt_count = 2.
- cfg_mask = 0x00F and irq asserted in the same S_IDLE cycle → mask write first, cfg_mask_ready pulses; a later toggle of switch 5 leaves irq low and produces no event; a toggle of switch 2 produces evt_edges = 0x004.
- Force the spurious path (irq high, edge_capture masked to 0 at read) → no evt_valid; FSM returns to S_IDLE after S_LAT; evt_count unchanged.
- reset_n pulsed low during S_OUT → evt_valid drops asynchronously; the sequence restarts with the mask write of 0x3FF and evt_count = 0.
